// File: rtl/serial_pal_n.sv
// Serial-to-parallel converter: shifts one bit per enabled clock into a WIDTH-bit word,
// then holds each complete word under a valid/ready handshake and flags overrun.
//
// state | meaning
// EMPTY | out holds no unconsumed word (valid=0)
// FULL  | out holds an unconsumed word (valid=1)
module serial_pal_n #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic                     in,
   input  logic                     clr,
   input  logic                     ready,
   output logic [WIDTH-1:0]         shift,
   output logic [WIDTH-1:0]         out,
   output logic                     valid,
   output logic                     overrun,
   output logic [$clog2(WIDTH)-1:0] bit_cnt
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shift_nxt;
   logic             done;

   generate
      if (MSB_FIRST) begin : g_msb
         assign shift_nxt = {shift[WIDTH-2:0], in};
      end else begin : g_lsb
         assign shift_nxt = {in, shift[WIDTH-1:1]};
      end
   endgenerate

   // The word completes on the edge that samples its last bit, so out takes shift_nxt.
   assign done  = en && (bit_cnt == LAST);
   assign valid = (state == FULL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= EMPTY;
         shift   <= '0;
         out     <= '0;
         overrun <= 1'b0;
         bit_cnt <= '0;
      end else if (clr) begin
         state   <= EMPTY;
         shift   <= '0;
         overrun <= 1'b0;
         bit_cnt <= '0;
      end else begin
         if (en) begin
            shift   <= shift_nxt;
            bit_cnt <= done ? '0 : bit_cnt + 1'b1;
         end
         case (state)
            EMPTY: begin
               if (done) begin
                  out   <= shift_nxt;
                  state <= FULL;
               end
            end
            FULL: begin
               if (done) begin
                  out <= shift_nxt;
                  if (!ready)
                     overrun <= 1'b1;
               end else if (ready) begin
                  state <= EMPTY;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule
